bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter; the inverse path of the binary-to-BCD display decoder.
- Takes a packed multi-digit BCD word, e.g. from switch or keypad entry, and produces its binary value.
- Processes one digit per clock with acc = acc*10 + digit, most significant digit first.
- Uses a start/busy/done handshake and flags invalid digits and overflow.
- Output feeds counter preload and compare logic.

---
 rtl/bcd_to_bin_seq.sv | 119 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Flags invalid nibbles and results that do not fit in N bits.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int N      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [N-1:0]          bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_digit,
  output logic                  err_ovf
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [N+3:0] MAXV = {4'b0000, {N{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_shreg;
  logic [N+3:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_edig;
  logic            r_ovf;

  logic [3:0]      w_digit;
  logic [N+3:0]    w_x10;
  logic [N+3:0]    w_sum;
  logic            w_big;
  logic            w_last;

  // acc stays <= 2^N-1, so acc*10+15 always fits in N+4 bits
  assign w_digit = r_shreg[W-1 -: 4];
  assign w_x10   = (r_acc << 3) + (r_acc << 1);
  assign w_sum   = w_x10 + {{N{1'b0}}, w_digit};
  assign w_big   = (w_sum > MAXV);
  assign w_last  = (r_cnt == CW'(1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next-state and busy decode
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) w_next = FIN;
      end
      FIN: begin
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // datapath: capture, accumulate, publish results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_edig    <= 1'b0;
      r_ovf     <= 1'b0;
      bin_out   <= '0;
      done      <= 1'b0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shreg <= bcd_in;
            r_acc   <= '0;
            r_cnt   <= CW'(DIGITS);
            r_edig  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        CONV: begin
          r_shreg <= r_shreg << 4;
          r_cnt   <= r_cnt - CW'(1);
          r_acc   <= (r_ovf || w_big) ? MAXV : w_sum;
          if (w_digit > 4'd9) r_edig <= 1'b1;
          if (w_big)          r_ovf  <= 1'b1;
        end
        FIN: begin
          done      <= 1'b1;
          err_digit <= r_edig;
          err_ovf   <= r_ovf;
          if (r_edig)     bin_out <= '0;
          else if (r_ovf) bin_out <= '1;
          else            bin_out <= r_acc[N-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: N=14 instance plus an N=10
// instance sharing stimulus for the overflow cases.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;

  logic [13:0] a_bin;
  logic        a_busy, a_done, a_ed, a_eo;
  logic [9:0]  b_bin;
  logic        b_busy, b_done, b_ed, b_eo;

  int n_cmp = 0;
  int n_err = 0;
  int g_lat;
  int g_nb;
  int nd;
  int cyc;
  int d1, d2, d3;

  bcd_to_bin_seq #(.DIGITS(4), .N(14)) u_a (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .bin_out(a_bin), .busy(a_busy), .done(a_done),
    .err_digit(a_ed), .err_ovf(a_eo)
  );

  bcd_to_bin_seq #(.DIGITS(4), .N(10)) u_b (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .bin_out(b_bin), .busy(b_busy), .done(b_done),
    .err_digit(b_ed), .err_ovf(b_eo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one conversion; g_lat = edges from start to done, g_nb = busy cycles
  task automatic run(input logic [15:0] v);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    g_lat = 0;
    g_nb  = 0;
    while (!a_done && g_lat < 20) begin
      if (a_busy) g_nb++;
      @(negedge clk);
      g_lat++;
    end
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bin",  32'(a_bin), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_ed",   32'(a_ed), 0);
    chk("rst_eo",   32'(a_eo), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(16'h1234);
    chk("1234_lat",  g_lat, 5);
    chk("1234_busy", g_nb, 5);
    chk("1234_bin",  32'(a_bin), 1234);
    chk("1234_ed",   32'(a_ed), 0);
    chk("1234_eo",   32'(a_eo), 0);
    @(negedge clk);
    chk("1234_pulse", 32'(a_done), 0);
    chk("1234_hold",  32'(a_bin), 1234);

    run(16'h0000);
    chk("0000_bin", 32'(a_bin), 0);

    run(16'h9999);
    chk("9999_bin",  32'(a_bin), 9999);
    chk("9999_ed",   32'(a_ed), 0);
    chk("9999_eo",   32'(a_eo), 0);
    chk("n10_9999_bin", 32'(b_bin), 32'h3FF);
    chk("n10_9999_eo",  32'(b_eo), 1);

    run(16'h12A4);
    chk("12A4_lat", g_lat, 5);
    chk("12A4_ed",  32'(a_ed), 1);
    chk("12A4_bin", 32'(a_bin), 0);
    chk("12A4_eo",  32'(a_eo), 0);
    chk("n10_12A4_ed",  32'(b_ed), 1);
    chk("n10_12A4_eo",  32'(b_eo), 1);
    chk("n10_12A4_bin", 32'(b_bin), 0);

    run(16'h0042);
    chk("0042_bin", 32'(a_bin), 42);
    chk("0042_ed",  32'(a_ed), 0);

    run(16'h1023);
    chk("n10_1023_bin", 32'(b_bin), 1023);
    chk("n10_1023_eo",  32'(b_eo), 0);

    run(16'h1024);
    chk("n10_1024_bin", 32'(b_bin), 32'h3FF);
    chk("n10_1024_eo",  32'(b_eo), 1);
    chk("1024_bin",     32'(a_bin), 1024);

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0005;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0777;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    chk("busy_ign_cnt", nd, 1);
    chk("busy_ign_bin", 32'(a_bin), 5);

    // start held high: back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0010;
    d1 = -1;
    d2 = -1;
    d3 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_done) begin
        if (d1 < 0)      d1 = i;
        else if (d2 < 0) d2 = i;
        else if (d3 < 0) d3 = i;
      end
    end
    start = 1'b0;
    chk("b2b_first", d1, 5);
    chk("b2b_gap1",  d2 - d1, 6);
    chk("b2b_gap2",  d3 - d2, 6);
    chk("b2b_bin",   32'(a_bin), 10);
    repeat (10) @(negedge clk);

    // asynchronous reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h4321;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(a_busy), 0);
    chk("arst_bin",  32'(a_bin), 0);
    chk("arst_done", 32'(a_done), 0);
    chk("arst_ed",   32'(a_ed), 0);
    chk("arst_eo",   32'(a_eo), 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    chk("arst_nodone", nd, 0);
    rst = 1'b1;
    @(negedge clk);

    run(16'h0001);
    chk("post_lat", g_lat, 5);
    chk("post_bin", 32'(a_bin), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
